hilo_divider: RTL and testbench

Multi-cycle integer divider that sequences all DIV/DIVU writes into the HI/LO register pair. It sits in the execute stage, accepts one divide request at a time and stalls the pipeline while iterating. On completion it drives one-cycle HI/LO write-enable pulses: HI receives the remainder and LO receives the quotient. A flush input cancels an in-flight divide without writing.

---
 rtl/hilo_divider_pkg.sv | 15 +
 rtl/hilo_divider_div_step.sv | 31 +++
 rtl/hilo_divider.sv | 137 +++++++++++++
 tb/tb_hilo_divider.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_divider_pkg.sv
// Shared types and constants for the HI/LO multi-cycle divider.
// Imported by the divider top and its iteration step.
package hilo_divider_pkg;

  localparam int DIV_ITERATIONS = 32;
  localparam logic RESET_ENABLE = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DIV_ZERO = 2'd1,
    S_RUNNING  = 2'd2,
    S_DONE     = 2'd3
  } div_state_t;

endpackage

// File: rtl/hilo_divider_div_step.sv
// One restoring shift-subtract iteration, purely combinational.
// The quotient register doubles as the dividend shift source.
module hilo_divider_div_step
  import hilo_divider_pkg::*;
#(
  parameter int WIDTH = DIV_ITERATIONS
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_i, quo_i[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvsr_i};

  // A clear borrow bit means the divisor fit: keep the difference.
  always_comb begin
    rem_o = shifted[WIDTH-1:0];
    quo_o = {quo_i[WIDTH-2:0], 1'b0};
    if (!diff[WIDTH]) begin
      rem_o = diff[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/hilo_divider.sv
// Multi-cycle DIV/DIVU unit feeding the HI/LO register pair.
// Remainder goes to HI, quotient to LO, as one-cycle write pulses.
module hilo_divider
  import hilo_divider_pkg::*;
#(
  parameter int WIDTH = DIV_ITERATIONS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             busy,
  output logic             stall_request,
  output logic             register_hi_write_enable,
  output logic [WIDTH-1:0] register_hi_write_data,
  output logic             register_lo_write_enable,
  output logic [WIDTH-1:0] register_lo_write_data
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_t       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvsr_q;
  logic             qneg_q;
  logic             rneg_q;
  logic             we_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;

  assign dvd_neg = signed_op & dividend[WIDTH-1];
  assign dvs_neg = signed_op & divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dvs_mag = dvs_neg ? -divisor : divisor;

  hilo_divider_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem),
    .quo_o  (step_quo)
  );

  // Sign fix-up applied to the final step's output.
  assign hi_d = rneg_q ? -step_rem : step_rem;
  assign lo_d = qneg_q ? -step_quo : step_quo;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      we_q    <= RESET_ENABLE;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (cancel) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            dvsr_q <= dvs_mag;
            qneg_q <= dvd_neg ^ dvs_neg;
            rneg_q <= dvd_neg;
            if (divisor == '0) begin
              quo_q   <= dividend;
              state_q <= S_DIV_ZERO;
            end else begin
              quo_q   <= dvd_mag;
              state_q <= S_RUNNING;
            end
          end
        end
        S_DIV_ZERO: begin
          hi_q    <= quo_q;
          lo_q    <= '1;
          we_q    <= 1'b1;
          state_q <= S_DONE;
        end
        S_RUNNING: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            we_q    <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign stall_request = (state_q == S_DIV_ZERO) ||
                         (state_q == S_RUNNING);

  assign register_hi_write_enable = we_q;
  assign register_lo_write_enable = we_q;
  assign register_hi_write_data   = hi_q;
  assign register_lo_write_data   = lo_q;

endmodule

// File: tb/tb_hilo_divider.sv
// Directed scoreboard bench for hilo_divider.
// Expected HI/LO pairs are queued at start and popped on the pulse.
module tb_hilo_divider;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        cancel;
  logic        busy;
  logic        stall;
  logic        hi_we;
  logic [31:0] hi_d;
  logic        lo_we;
  logic [31:0] lo_d;

  int checks = 0;
  int failures = 0;
  logic [63:0] sb[$];

  always #5 clock = ~clock;

  hilo_divider #(
    .WIDTH (32)
  ) dut (
    .clock                    (clock),
    .reset                    (reset),
    .start                    (start),
    .signed_op                (signed_op),
    .dividend                 (dividend),
    .divisor                  (divisor),
    .cancel                   (cancel),
    .busy                     (busy),
    .stall_request            (stall),
    .register_hi_write_enable (hi_we),
    .register_hi_write_data   (hi_d),
    .register_lo_write_enable (lo_we),
    .register_lo_write_data   (lo_d)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: {HI, LO}.
  function automatic logic [63:0] model(input logic sg,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (sg) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Issue one divide and follow it to its pulse. poke>0 re-asserts
  // start with other operands in that cycle of the operation.
  task automatic run_div(input string tag,
                         input logic sg,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input int poke);
    logic [63:0] e;
    int lat;
    int n;
    bit seen;
    sb.push_back(model(sg, a, b));
    lat = (b == 32'd0) ? 2 : 33;
    signed_op = sg;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    seen = 1'b0;
    while (!seen && n <= 40) begin
      if (n == poke) begin
        start     = 1'b1;
        signed_op = ~sg;
        dividend  = ~a;
        divisor   = 32'd3;
      end else begin
        start = 1'b0;
      end
      if (hi_we) begin
        seen = 1'b1;
        e = sb.pop_front();
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        chk({tag, "_lowe"}, 64'(lo_we), 64'd1);
        chk({tag, "_hi"}, 64'(hi_d), 64'(e[63:32]));
        chk({tag, "_lo"}, 64'(lo_d), 64'(e[31:0]));
        chk({tag, "_stall_done"}, 64'(stall), 64'd0);
      end else begin
        chk({tag, "_stall_run"}, 64'(stall), 64'd1);
        chk({tag, "_lowe_off"}, 64'(lo_we), 64'd0);
      end
      tick();
      n++;
    end
    start = 1'b0;
    chk({tag, "_timeout"}, 64'(seen), 64'd1);
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    chk({tag, "_we_after"}, 64'(hi_we), 64'd0);
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    int pulses;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      if (hi_we || lo_we) pulses++;
      tick();
    end
    chk({tag, "_no_pulse"}, 64'(pulses), 64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = 32'd0;
    divisor   = 32'd0;
    cancel    = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_we", 64'({hi_we, lo_we}), 64'd0);
    chk("rst_data", {hi_d, lo_d}, 64'd0);

    run_div("u100_7", 1'b0, 32'd100, 32'd7, 0);
    chk("u100_7_lo_const", 64'(lo_d), 64'd14);
    chk("u100_7_hi_const", 64'(hi_d), 64'd2);
    run_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    chk("s_m7_2_lo_const", 64'(lo_d), 64'hFFFF_FFFD);
    chk("s_m7_2_hi_const", 64'(hi_d), 64'hFFFF_FFFF);
    run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    chk("s_7_m2_lo_const", 64'(lo_d), 64'hFFFF_FFFD);
    chk("s_7_m2_hi_const", 64'(hi_d), 64'd1);
    run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("s_ovf_lo_const", 64'(lo_d), 64'h8000_0000);
    run_div("u_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("u_ovf_hi_const", 64'(hi_d), 64'h8000_0000);
    run_div("dz_s", 1'b1, 32'h0000_1234, 32'd0, 0);
    run_div("dz_u", 1'b0, 32'h0000_1234, 32'd0, 0);
    run_div("u_big", 1'b0, 32'hDEAD_BEEF, 32'h0000_1001, 0);
    run_div("s_mix", 1'b1, 32'h8765_4321, 32'h0000_0123, 0);

    // Cancel in cycle k+10 of a running divide.
    signed_op = 1'b0;
    dividend  = 32'd1000;
    divisor   = 32'd9;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    chk("cx_busy_before", 64'(busy), 64'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cx_idle", 64'(busy), 64'd0);
    chk("cx_we", 64'(hi_we), 64'd0);
    run_div("cx_restart", 1'b0, 32'd1000, 32'd9, 0);

    // cancel and start together in IDLE.
    dividend = 32'd50;
    divisor  = 32'd5;
    start    = 1'b1;
    cancel   = 1'b1;
    tick();
    start  = 1'b0;
    cancel = 1'b0;
    chk("cs_busy", 64'(busy), 64'd0);
    watch_quiet("cs", 40);

    run_div("poke", 1'b0, 32'd100, 32'd7, 5);

    // Reset in cycle k+20.
    signed_op = 1'b1;
    dividend  = 32'd12345;
    divisor   = 32'd17;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 20; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_stall", 64'(stall), 64'd0);
    chk("mr_we", 64'({hi_we, lo_we}), 64'd0);
    chk("mr_data", {hi_d, lo_d}, 64'd0);
    watch_quiet("mr", 40);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
